vga_sync_decoder: RTL and testbench

Recovers VGA raster timing from an incoming horizontal/vertical sync pair and regenerates pixel coordinates, so capture, overlay and loopback-check logic can work from sync pins alone. It is the receive-side counterpart of the console's sync generator. It sits on `pixel_clock`, with sync inputs synchronous to that clock. It measures line and frame length, tracks alignment, and reports lock.

---
 rtl/vga_sync_decoder.sv | 171 +++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers raster timing and pixel coordinates
// from an hsync/vsync pair, measures line/frame length, reports lock.
module vga_sync_decoder #(
  parameter int POSITION_WIDTH = 10,
  parameter logic [POSITION_WIDTH-1:0] H_VISIBLE_AREA = POSITION_WIDTH'(640),
  parameter logic [POSITION_WIDTH-1:0] H_BACK_PORCH = POSITION_WIDTH'(48),
  parameter logic H_ACTIVE_POLARITY = 1'b0,
  parameter logic [POSITION_WIDTH-1:0] V_VISIBLE_AREA = POSITION_WIDTH'(480),
  parameter logic [POSITION_WIDTH-1:0] V_BACK_PORCH = POSITION_WIDTH'(33),
  parameter logic V_ACTIVE_POLARITY = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                      pixel_clock,
  input  logic                      reset,
  input  logic                      vga_horizontal_sync,
  input  logic                      vga_vertical_sync,
  output logic [POSITION_WIDTH-1:0] h_position,
  output logic [POSITION_WIDTH-1:0] v_position,
  output logic                      visible_area,
  output logic                      frame_start,
  output logic [POSITION_WIDTH-1:0] h_total,
  output logic [POSITION_WIDTH-1:0] v_total,
  output logic                      locked
);

  localparam int PW = POSITION_WIDTH;
  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [PW-1:0] ONES = '1;

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } state_t;

  state_t state_q, state_d;
  logic [2:0] good_q, good_d, good_inc;
  logic h_mismatch_q, h_mismatch_d;

  logic h_sync_q, v_sync_q;
  logic h_act, v_act;
  logic h_act_d, v_act_d;
  logic h_fall, v_fall;
  logic h_wrap;
  logic h_mis, v_mis;
  logic frame_ok, timeout;

  logic [PW-1:0] h_count, v_count;
  logic [PW-1:0] h_period, v_period;

  assign h_act = ~(h_sync_q ^ H_ACTIVE_POLARITY);
  assign v_act = ~(v_sync_q ^ V_ACTIVE_POLARITY);
  assign h_fall = h_act_d & ~h_act;
  assign v_fall = v_act_d & ~v_act;

  assign h_period = h_count + ONE;
  assign v_period = v_count + ONE;
  assign h_wrap = ~h_fall & (h_position == h_total - ONE);

  assign h_mis = h_fall & (h_period != h_total);
  assign v_mis = v_fall & (v_period != v_total);
  assign timeout = (h_count == ONES) | (v_count == ONES);

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      h_sync_q <= ~H_ACTIVE_POLARITY;
      v_sync_q <= ~V_ACTIVE_POLARITY;
      h_act_d <= 1'b0;
      v_act_d <= 1'b0;
    end else begin
      h_sync_q <= vga_horizontal_sync;
      v_sync_q <= vga_vertical_sync;
      h_act_d <= h_act;
      v_act_d <= v_act;
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      h_count <= '0;
      h_total <= '0;
      h_position <= '0;
    end else begin
      if (h_fall) begin
        h_count <= '0;
        h_total <= h_period;
        h_position <= h_period - H_BACK_PORCH;
      end else begin
        if (h_count != ONES) h_count <= h_period;
        h_position <= h_wrap ? '0 : h_position + ONE;
      end
    end
  end

  // vsync load wins over a coincident line wrap
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      v_count <= '0;
      v_total <= '0;
      v_position <= '0;
    end else if (v_fall) begin
      v_count <= '0;
      v_total <= v_period;
      v_position <= v_period - V_BACK_PORCH;
    end else if (h_wrap) begin
      if (v_count != ONES) v_count <= v_period;
      if (v_position == v_total - ONE) v_position <= '0;
      else v_position <= v_position + ONE;
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state_q <= SEARCH;
      good_q <= '0;
      h_mismatch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q <= good_d;
      h_mismatch_q <= h_mismatch_d;
    end
  end

  assign good_inc = good_q + 3'd1;
  assign frame_ok = ~h_mismatch_q & ~h_mis & ~v_mis;

  always_comb begin
    state_d = state_q;
    good_d = good_q;
    h_mismatch_d = h_mismatch_q | h_mis;
    unique case (state_q)
      SEARCH: begin
        if (v_fall) begin
          state_d = TRACK;
          good_d = '0;
          h_mismatch_d = 1'b0;
        end
      end
      TRACK: begin
        if (v_fall) begin
          h_mismatch_d = 1'b0;
          if (frame_ok) begin
            good_d = good_inc;
            if (good_inc == 3'(LOCK_FRAMES)) state_d = LOCKED;
          end else begin
            good_d = '0;
          end
        end
      end
      LOCKED: begin
        if (h_mis | v_mis) begin
          state_d = TRACK;
          good_d = '0;
        end
      end
      default: state_d = SEARCH;
    endcase
    if (timeout) begin
      state_d = SEARCH;
      good_d = '0;
    end
  end

  assign locked = (state_q == LOCKED);
  assign visible_area = locked &
    (h_position < H_VISIBLE_AREA) &
    (v_position < V_VISIBLE_AREA);
  assign frame_start = locked &
    (h_position == '0) & (v_position == '0);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: small raster, active-low and
// active-high instances driven from one pattern generator.
module tb_vga_sync_decoder;

  localparam int PW = 8;
  localparam int HT = 16;
  localparam int VT = 11;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic hs0, vs0, hs1, vs1;
  logic [PW-1:0] h0, v0, ht0, vt0;
  logic [PW-1:0] h1, v1, ht1, vt1;
  logic vis0, fs0, lk0;
  logic vis1, fs1, lk1;

  vga_sync_decoder #(
    .POSITION_WIDTH(PW),
    .H_VISIBLE_AREA(8'd8),
    .H_BACK_PORCH(8'd3),
    .H_ACTIVE_POLARITY(1'b0),
    .V_VISIBLE_AREA(8'd6),
    .V_BACK_PORCH(8'd2),
    .V_ACTIVE_POLARITY(1'b0),
    .LOCK_FRAMES(2)
  ) dut0 (
    .pixel_clock(clk),
    .reset(reset),
    .vga_horizontal_sync(hs0),
    .vga_vertical_sync(vs0),
    .h_position(h0),
    .v_position(v0),
    .visible_area(vis0),
    .frame_start(fs0),
    .h_total(ht0),
    .v_total(vt0),
    .locked(lk0)
  );

  vga_sync_decoder #(
    .POSITION_WIDTH(PW),
    .H_VISIBLE_AREA(8'd8),
    .H_BACK_PORCH(8'd3),
    .H_ACTIVE_POLARITY(1'b1),
    .V_VISIBLE_AREA(8'd6),
    .V_BACK_PORCH(8'd2),
    .V_ACTIVE_POLARITY(1'b1),
    .LOCK_FRAMES(2)
  ) dut1 (
    .pixel_clock(clk),
    .reset(reset),
    .vga_horizontal_sync(hs1),
    .vga_vertical_sync(vs1),
    .h_position(h1),
    .v_position(v1),
    .visible_area(vis1),
    .frame_start(fs1),
    .h_total(ht1),
    .v_total(vt1),
    .locked(lk1)
  );

  int checks = 0;
  int fails = 0;
  int gx, gy, sx, sy, ox, oy;
  int skip_x, skip_y;
  logic hold_h;

  // h: 8 visible, 2 front, 3 sync, 3 back; v: 6, 1, 2, 2
  function automatic logic h_sync_on(int x);
    return (x >= 10) && (x < 13);
  endfunction

  function automatic logic v_sync_on(int y);
    return (y >= 7) && (y < 9);
  endfunction

  // ox/oy: pixel whose decoded outputs are visible now
  task automatic drive_pixel();
    logic ha;
    ha = h_sync_on(gx) & ~hold_h;
    hs0 = ~ha;
    hs1 = ha;
    vs0 = ~v_sync_on(gy);
    vs1 = v_sync_on(gy);
    @(posedge clk);
    #1;
    ox = sx;
    oy = sy;
    sx = gx;
    sy = gy;
    gx = gx + 1;
    if (gy == skip_y && gx == skip_x) begin
      gx = gx + 1;
      skip_y = -1;
    end
    if (gx == HT) begin
      gx = 0;
      gy = (gy == VT - 1) ? 0 : gy + 1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) drive_pixel();
    checks++;
    if (h0 !== '0) begin
      fails++; $display("FAIL reset_h_position: got %0d want 0", h0);
    end
    checks++;
    if (v0 !== '0) begin
      fails++; $display("FAIL reset_v_position: got %0d want 0", v0);
    end
    checks++;
    if (ht0 !== '0) begin
      fails++; $display("FAIL reset_h_total: got %0d want 0", ht0);
    end
    checks++;
    if (vt0 !== '0) begin
      fails++; $display("FAIL reset_v_total: got %0d want 0", vt0);
    end
    checks++;
    if ({vis0, fs0, lk0} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: got %b want 000", {vis0, fs0, lk0});
    end
    checks++;
    if ({vis1, fs1, lk1} !== 3'b000) begin
      fails++; $display("FAIL reset_flags_inv: got %b want 000", {vis1, fs1, lk1});
    end
  endtask

  task automatic test_lock();
    int edges;
    logic exp_lk;
    edges = 0;
    reset = 1'b0;
    for (int i = 0; i < 5 * FRAME; i++) begin
      drive_pixel();
      if (ox == 0 && oy == 9) edges++;
      exp_lk = (edges >= 4);
      checks++;
      if (lk0 !== exp_lk) begin
        fails++; $display("FAIL lock_seq: locked %b want %b at vedge %0d", lk0, exp_lk, edges);
      end
      checks++;
      if (lk1 !== lk0) begin
        fails++; $display("FAIL lock_inv: locked %b want %b", lk1, lk0);
      end
      if (edges >= 4) begin
        checks++;
        if (h0 !== PW'(ox) || v0 !== PW'(oy)) begin
          fails++; $display("FAIL position: got (%0d,%0d) want (%0d,%0d)", h0, v0, ox, oy);
        end
        checks++;
        if (vis0 !== (ox < 8 && oy < 6)) begin
          fails++; $display("FAIL visible_at: got %b at (%0d,%0d)", vis0, ox, oy);
        end
        checks++;
        if (fs0 !== (ox == 0 && oy == 0)) begin
          fails++; $display("FAIL frame_start_at: got %b at (%0d,%0d)", fs0, ox, oy);
        end
        checks++;
        if (h1 !== h0 || v1 !== v0 || vis1 !== vis0 || fs1 !== fs0) begin
          fails++; $display("FAIL position_inv: got (%0d,%0d) want (%0d,%0d)", h1, v1, h0, v0);
        end
      end
    end
    checks++;
    if (ht0 !== PW'(HT) || ht1 !== PW'(HT)) begin
      fails++; $display("FAIL h_total: got %0d/%0d want %0d", ht0, ht1, HT);
    end
    checks++;
    if (vt0 !== PW'(VT) || vt1 !== PW'(VT)) begin
      fails++; $display("FAIL v_total: got %0d/%0d want %0d", vt0, vt1, VT);
    end
  endtask

  task automatic test_visible();
    int nv0, nf0, nv1, nf1;
    nv0 = 0; nf0 = 0; nv1 = 0; nf1 = 0;
    for (int i = 0; i < FRAME; i++) begin
      drive_pixel();
      nv0 += int'(vis0); nf0 += int'(fs0);
      nv1 += int'(vis1); nf1 += int'(fs1);
    end
    checks++;
    if (nv0 != 48) begin
      fails++; $display("FAIL visible_count: got %0d want 48", nv0);
    end
    checks++;
    if (nf0 != 1) begin
      fails++; $display("FAIL frame_start_count: got %0d want 1", nf0);
    end
    checks++;
    if (nv1 != 48 || nf1 != 1) begin
      fails++; $display("FAIL visible_inv: got %0d/%0d want 48/1", nv1, nf1);
    end
  endtask

  task automatic test_line_glitch();
    int edges;
    bit seen;
    edges = 0;
    seen = 0;
    skip_x = 5;
    skip_y = 2;
    for (int i = 0; i < 5 * FRAME && edges < 3; i++) begin
      drive_pixel();
      if (!seen && ox == 12 && oy == 2) begin
        checks++;
        if (lk0 !== 1'b1) begin
          fails++; $display("FAIL glitch_pre: locked %b want 1", lk0);
        end
      end
      if (!seen && ox == 13 && oy == 2) begin
        seen = 1;
        checks++;
        if (lk0 !== 1'b0 || lk1 !== 1'b0) begin
          fails++; $display("FAIL glitch_drop: locked %b/%b want 0", lk0, lk1);
        end
      end
      if (seen && ox == 0 && oy == 9) begin
        edges++;
        checks++;
        if (lk0 !== (edges >= 3)) begin
          fails++; $display("FAIL glitch_relock: locked %b at vedge %0d", lk0, edges);
        end
      end
    end
    checks++;
    if (edges != 3) begin
      fails++; $display("FAIL glitch_bound: got %0d vedges want 3", edges);
    end
  endtask

  task automatic test_sync_loss();
    for (int i = 0; i < 2 * HT && gx != 0; i++) drive_pixel();
    hold_h = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      drive_pixel();
      if (i == 100) begin
        checks++;
        if (lk0 !== 1'b1) begin
          fails++; $display("FAIL loss_early: locked %b want 1", lk0);
        end
      end
    end
    checks++;
    if ({lk0, vis0, fs0} !== 3'b000) begin
      fails++; $display("FAIL loss_state: got %b want 000", {lk0, vis0, fs0});
    end
    checks++;
    if ({lk1, vis1} !== 2'b00) begin
      fails++; $display("FAIL loss_state_inv: got %b want 00", {lk1, vis1});
    end
    hold_h = 1'b0;
    for (int i = 0; i < 6 * FRAME && lk0 !== 1'b1; i++) drive_pixel();
    checks++;
    if (lk0 !== 1'b1) begin
      fails++; $display("FAIL loss_relock: locked %b want 1", lk0);
    end
  endtask

  task automatic test_midframe_reset();
    int edges;
    for (int i = 0; i < FRAME && !(sx == 3 && sy == 4); i++) drive_pixel();
    reset = 1'b1;
    drive_pixel();
    checks++;
    if (h0 !== '0 || v0 !== '0 || ht0 !== '0 || vt0 !== '0) begin
      fails++; $display("FAIL midreset_regs: got %0d %0d %0d %0d want 0", h0, v0, ht0, vt0);
    end
    checks++;
    if ({vis0, fs0, lk0, lk1} !== 4'b0000) begin
      fails++; $display("FAIL midreset_flags: got %b want 0000", {vis0, fs0, lk0, lk1});
    end
    reset = 1'b0;
    edges = 0;
    for (int i = 0; i < 5 * FRAME; i++) begin
      drive_pixel();
      if (ox == 0 && oy == 9) begin
        edges++;
        checks++;
        if (lk0 !== (edges >= 4)) begin
          fails++; $display("FAIL midreset_relock: locked %b at vedge %0d", lk0, edges);
        end
      end
    end
    checks++;
    if (lk0 !== 1'b1 || ht0 !== PW'(HT) || vt0 !== PW'(VT)) begin
      fails++; $display("FAIL midreset_final: locked %b totals %0d/%0d", lk0, ht0, vt0);
    end
  endtask

  initial begin
    reset = 1'b1;
    hold_h = 1'b0;
    hs0 = 1'b1; vs0 = 1'b1;
    hs1 = 1'b0; vs1 = 1'b0;
    gx = 5; gy = 3;
    sx = -1; sy = -1; ox = -1; oy = -1;
    skip_x = -1; skip_y = -1;
    test_reset();
    test_lock();
    test_visible();
    test_line_glitch();
    test_sync_loss();
    test_midframe_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
